dcm_reset_ctrl: RTL

DCM_RESET_CTRL -- requirements
Module: dcm_reset_ctrl

---
 rtl/dcm_ctrl_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/dcm_reset_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/dcm_ctrl_pkg.sv
// Shared types for the DCM reset controller: FSM state encoding, counter width
// and a saturating increment used by the statistics counters.
package dcm_ctrl_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    HOLD      = 2'b00,
    WAIT_LOCK = 2'b01,
    STABLE    = 2'b10,
    RUN       = 2'b11
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset low.
// Both flops carry ASYNC_REG so placement keeps them adjacent with no logic between.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic meta_q;
  (* ASYNC_REG = "TRUE" *) logic sync_q;

  // Metastability-settling shift pair.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dcm_reset_ctrl.sv
// DCM reset sequencer: pulses the DCM reset, waits for a stable lock with a
// timeout/retry loop, then releases downstream reset; counts relocks and timeouts.
module dcm_reset_ctrl
  import dcm_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned STABLE_CYCLES  = 256
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       locked,
  output logic       dcm_rst,
  output logic       ready,
  output logic       sys_rst_n,
  output logic [7:0] relock_cnt,
  output logic [7:0] fail_cnt
);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  logic             locked_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       relock_q, relock_d;
  logic [7:0]       fail_q, fail_d;
  logic             dcm_rst_q, dcm_rst_d;
  logic             ready_q, ready_d;

  sync_2ff u_sync_locked (
    .clk_i   (fclk),
    .rst_n_i (rst_n),
    .d_i     (locked),
    .q_o     (locked_s)
  );

  // Next-state, counter and statistics logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 16'd1;
    relock_d = relock_q;
    fail_d   = fail_q;
    case (state_q)
      HOLD: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = 16'd0;
        end else begin
          state_d = HOLD;
        end
      end
      WAIT_LOCK: begin
        // Lock arriving on the timeout cycle wins over the retry.
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = 16'd0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = HOLD;
          cnt_d   = 16'd0;
          fail_d  = sat_inc8(fail_q);
        end else begin
          state_d = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = HOLD;
          cnt_d   = 16'd0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = 16'd0;
        end else begin
          state_d = STABLE;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d  = HOLD;
          cnt_d    = 16'd0;
          relock_d = sat_inc8(relock_q);
        end else begin
          state_d = RUN;
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = 16'd0;
      end
    endcase
    // Outputs are registered from the next state so they track the state register glitch-free.
    dcm_rst_d = (state_d == HOLD);
    ready_d   = (state_d == RUN);
  end

  // State, counter, statistics and output registers.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HOLD;
      cnt_q     <= 16'd0;
      relock_q  <= 8'd0;
      fail_q    <= 8'd0;
      dcm_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      relock_q  <= relock_d;
      fail_q    <= fail_d;
      dcm_rst_q <= dcm_rst_d;
      ready_q   <= ready_d;
    end
  end

  assign dcm_rst    = dcm_rst_q;
  assign ready      = ready_q;
  assign sys_rst_n  = ready_q;
  assign relock_cnt = relock_q;
  assign fail_cnt   = fail_q;

endmodule
